// File: rtl/wb4_fifo_drain_master_pkg.sv
// Shared definitions for the WB4 FIFO drain master: FSM state encoding.
package wb4_fifo_drain_master_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/wb4_fifo_drain_master_buf.sv
// Single-clock return buffer with registered storage, occupancy count and empty flag.
module wb4_fifo_drain_master_buf #(
  parameter int unsigned P_DATA_MSB  = 7,
  parameter int unsigned P_BUF_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              push_i,
  input  logic [P_DATA_MSB:0]               data_i,
  input  logic                              pop_i,
  output logic [P_DATA_MSB:0]               data_o,
  output logic [$clog2(P_BUF_DEPTH):0]      count_o,
  output logic                              empty_o
);

  localparam int unsigned PtrW = $clog2(P_BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(P_BUF_DEPTH);

  logic [P_DATA_MSB:0] mem_q [P_BUF_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                full;
  logic                empty;
  logic                do_push;
  logic                do_pop;

  always_comb begin
    full     = (count_q == DepthC);
    empty    = (count_q == '0);
    do_pop   = pop_i & ~empty;
    // A push into a full buffer is only legal when a word leaves the same cycle.
    do_push  = push_i & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty;

endmodule

// File: rtl/wb4_fifo_drain_master.sv
// Wishbone B4 pipelined read initiator that drains a FIFO read port into a valid/ready stream,
// never requesting more words than the local return buffer can hold.
module wb4_fifo_drain_master
  import wb4_fifo_drain_master_pkg::*;
#(
  parameter int unsigned P_DATA_MSB  = 7,
  parameter int unsigned P_LEN_MSB   = 7,
  parameter int unsigned P_BUF_DEPTH = 4
) (
  input  logic                i_wb4_mclk,
  input  logic                i_wb4_mrst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [P_LEN_MSB:0]  i_cmd_len,
  output logic                o_wb4_mcyc,
  output logic                o_wb4_mstb,
  input  logic                i_wb4_mstall,
  input  logic                i_wb4_mack,
  input  logic [P_DATA_MSB:0] i_wb4_mdata,
  output logic                o_data_valid,
  input  logic                i_data_ready,
  output logic [P_DATA_MSB:0] o_data,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned LenW = P_LEN_MSB + 1;
  localparam int unsigned CntW = $clog2(P_BUF_DEPTH) + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(P_BUF_DEPTH);

  state_e          state_q, state_d;
  logic [LenW-1:0] remaining_q, remaining_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            done_q, done_d;

  logic [CntW-1:0] buf_count;
  logic [CntW-1:0] buf_count_nxt;
  logic            buf_empty;
  logic [CntW:0]   reserved;
  logic            stb_accept;
  logic            ack_ok;
  logic            pop;

  wb4_fifo_drain_master_buf #(
    .P_DATA_MSB  (P_DATA_MSB),
    .P_BUF_DEPTH (P_BUF_DEPTH)
  ) u_buf (
    .clk_i   (i_wb4_mclk),
    .rst_i   (i_wb4_mrst),
    .push_i  (ack_ok),
    .data_i  (i_wb4_mdata),
    .pop_i   (pop),
    .data_o  (o_data),
    .count_o (buf_count),
    .empty_o (buf_empty)
  );

  always_comb begin
    stb_accept = stb_q & ~i_wb4_mstall;
    // Acks with nothing outstanding are stray and must not touch counters or the buffer.
    ack_ok     = i_wb4_mack & (outstanding_q != '0);
    pop        = ~buf_empty & i_data_ready;

    outstanding_d = outstanding_q;
    case ({stb_accept, ack_ok})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    buf_count_nxt = buf_count;
    case ({ack_ok, pop})
      2'b10:   buf_count_nxt = buf_count + CntW'(1);
      2'b01:   buf_count_nxt = buf_count - CntW'(1);
      default: buf_count_nxt = buf_count;
    endcase

    remaining_d = stb_accept ? remaining_q - LenW'(1) : remaining_q;
    state_d     = state_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          if (i_cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = StIssue;
            remaining_d = i_cmd_len;
          end
        end
      end
      StIssue: begin
        if (stb_accept && (remaining_q == LenW'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (outstanding_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    cyc_d = (state_d != StIdle);

    // Slots already spoken for next cycle: words in flight plus words sitting in the buffer.
    reserved = {1'b0, outstanding_d} + {1'b0, buf_count_nxt};
    if (stb_q && !stb_accept) begin
      stb_d = 1'b1;
    end else begin
      stb_d = (state_d == StIssue) && (remaining_d != '0) && (reserved < DepthC);
    end
  end

  always_ff @(posedge i_wb4_mclk) begin
    if (i_wb4_mrst) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      outstanding_q <= '0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      done_q        <= done_d;
    end
  end

  assign o_cmd_ready  = (state_q == StIdle);
  assign o_busy       = (state_q != StIdle);
  assign o_wb4_mcyc   = cyc_q;
  assign o_wb4_mstb   = stb_q;
  assign o_done       = done_q;
  assign o_data_valid = ~buf_empty;

endmodule
